// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: shared opcodes and FSM encoding for the MIPS mul/div unit
package mips_alu_pkg;
  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;
endpackage

// File: rtl/mips_muldiv_unit_if.sv
// mips_muldiv_unit_if: request/result bundle between control and the mul/div unit
interface mips_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;
  modport master (output start, op, a, b, input busy, done, hi, lo, div_by_zero);
  modport slave  (input start, op, a, b, output busy, done, hi, lo, div_by_zero);
endinterface

// File: rtl/mips_cond_negate.sv
// mips_cond_negate: two's-complement negation of a when neg is set
module mips_cond_negate #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);
  assign y = (a ^ {WIDTH{neg}}) + WIDTH'(neg);
endmodule

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative radix-2 MULT/MULTU/DIV/DIVU with HI/LO and MTHI/MTLO
module mips_muldiv_unit
  import mips_alu_pkg::*;
#(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  mips_muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] p, pn, nprod;
  logic [WIDTH-1:0]   m, ma, mb, nquo, nrem;
  logic [WIDTH:0]     sum, trial;
  logic               isdiv, sq, sr, bz, sgn, na, nb, acc;
  assign sgn = bus.op == OP_MULT || bus.op == OP_DIV;
  assign na = sgn & bus.a[WIDTH-1];
  assign nb = sgn & bus.b[WIDTH-1];
  assign acc = bus.start && state != S_RUN && bus.op <= OP_MTLO;
  assign bus.busy = state == S_RUN;
  // p holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
  assign sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
  assign trial = p[2*WIDTH-1:WIDTH-1] - {1'b0, m};
  assign pn = !isdiv ? {sum, p[WIDTH-1:1]} :
              trial[WIDTH] ? {p[2*WIDTH-2:0], 1'b0} : {trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
  mips_cond_negate #(.WIDTH(WIDTH)) u_nega (.a(bus.a), .neg(na), .y(ma));
  mips_cond_negate #(.WIDTH(WIDTH)) u_negb (.a(bus.b), .neg(nb), .y(mb));
  mips_cond_negate #(.WIDTH(2*WIDTH)) u_negp (.a(pn), .neg(sq), .y(nprod));
  mips_cond_negate #(.WIDTH(WIDTH)) u_negq (.a(pn[WIDTH-1:0]), .neg(sq), .y(nquo));
  mips_cond_negate #(.WIDTH(WIDTH)) u_negr (.a(pn[2*WIDTH-1:WIDTH]), .neg(sr), .y(nrem));
  // results are written on the edge entering FINISH so HI/LO are valid alongside DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      p <= '0;
      m <= '0;
      isdiv <= 1'b0;
      sq <= 1'b0;
      sr <= 1'b0;
      bz <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
      bus.done <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.div_by_zero <= 1'b0;
      if (state == S_RUN) begin
        p <= pn;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state <= S_FINISH;
          bus.done <= 1'b1;
          bus.div_by_zero <= bz;
          bus.hi <= isdiv ? nrem : nprod[2*WIDTH-1:WIDTH];
          bus.lo <= isdiv ? (bz ? '1 : nquo) : nprod[WIDTH-1:0];
        end
      end else if (acc && bus.op[2]) begin
        state <= S_IDLE;
        bus.done <= 1'b1;
        if (bus.op[0]) bus.lo <= bus.a;
        else bus.hi <= bus.a;
      end else if (acc) begin
        state <= S_RUN;
        cnt <= CW'(WIDTH);
        isdiv <= bus.op[1];
        sq <= na ^ nb;
        sr <= na;
        bz <= bus.op[1] && bus.b == '0;
        m <= bus.op[1] ? mb : ma;
        p <= {{WIDTH{1'b0}}, bus.op[1] ? ma : mb};
      end else begin
        state <= S_IDLE;
      end
    end
  end
endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers, parametrised in WIDTH. It sits beside the combinational ALU in the MIPS datapath and executes MULT/MULTU/DIV/DIVU over multiple cycles, plus single-cycle MTHI/MTLO. Control logic stalls on BUSY and reads results from HI/LO once DONE pulses.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO; legal values are >= 2.

Ports:
CLK  input  1  rising-edge clock.
RST  input  1  asynchronous reset, active-high.
START  input  1  request pulse; sampled only when BUSY=0.
OP  input  3  operation: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 110/111 reserved (ignored).
A  input  WIDTH  multiplicand/dividend; data source for MTHI/MTLO.
B  input  WIDTH  multiplier/divisor.
BUSY  output  1  high while a multiply or divide is iterating.
DONE  output  1  one-cycle pulse; HI/LO are valid in that same cycle.
HI  output  WIDTH  upper product, or remainder.
LO  output  WIDTH  lower product, or quotient.
DIV_BY_ZERO  output  1  high together with DONE when a divide has B=0.

Behaviour:
- Reset: RST=1 forces state IDLE immediately (asynchronous). BUSY=0, DONE=0, DIV_BY_ZERO=0, HI=0, LO=0, counter=0.
- Reset mid-operation aborts the operation. No DONE is produced and no partial result is written.
- States:
  - IDLE: accept START.
  - RUN: iterate.
  - FINISH: write results and pulse DONE.
- START is accepted on the edge where START=1, BUSY=0 and OP is not reserved. START while BUSY=1 is ignored and is not queued.
- MUL/DIV accept:
  - Latch A, B and OP into working registers.
  - For signed ops, convert the operands to magnitudes and record the result signs.
  - Load counter=WIDTH, go to RUN.
- RUN:
  - Perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - Decrement the counter. At counter=1, go to FINISH.
  - BUSY=1 for exactly WIDTH cycles.
- FINISH (one cycle): apply sign correction, write HI/LO, DONE=1, BUSY=0, then return to IDLE.
- Back-to-back: START is accepted in the FINISH cycle, and RUN begins next edge.
- Latency: accept edge at cycle 0 -> BUSY cycles 1..WIDTH -> DONE at cycle WIDTH+1.
- HI/LO hold their previous values throughout RUN. They change only in FINISH, on MTHI/MTLO, or on reset.
- Multiply: {HI,LO} = full 2*WIDTH-bit product. MULT is signed two's-complement; MULTU is unsigned.
- Divide: LO = quotient, HI = remainder.
  - DIV: quotient truncates toward zero; quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
  - DIV with A = most-negative value and B = -1: LO = most-negative value, HI = 0. No flag is raised.
- Divide by zero (B=0, DIV or DIVU):
  - Full latency still applies.
  - Result: HI = A, LO = all ones.
  - DIV_BY_ZERO=1 in the DONE cycle only.
- MTHI/MTLO: single cycle, no BUSY. The target register takes A on the accept edge, the other register is unchanged, and DONE pulses in the following cycle.
- DONE and DIV_BY_ZERO are registered outputs and are 0 in every cycle other than FINISH or the MTHI/MTLO acknowledge cycle.
- Counter width: $clog2(WIDTH)+1 bits.

Decomposition:
- Shared package mips_alu_pkg:
  - OP code localparams: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV, OP_MTHI, OP_MTLO.
  - State encoding: S_IDLE, S_RUN, S_FINISH.
- One sub-module, mips_cond_negate (parameter WIDTH): combinational conditional two's-complement. It is used for operand magnitude conversion and for result sign correction.
- The FSM and datapath stay in mips_muldiv_unit.

Test Plan:
All scenarios use WIDTH=32.
1. MULTU A=0xFFFFFFFF, B=0x00000002 -> BUSY high for 32 cycles, DONE at cycle 33, HI=0x00000001, LO=0xFFFFFFFE.
2. MULT A=0xFFFFFFFD (-3), B=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
3. DIV A=0xFFFFFFF9 (-7), B=0x00000002 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Then DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.
4. DIVU A=100, B=0 -> DONE with DIV_BY_ZERO=1, HI=0x00000064, LO=0xFFFFFFFF. The flag is 0 in the next cycle.
5. Assert START with OP=MTHI during BUSY -> request ignored, HI unchanged until FINISH. Then MTHI A=0x00001234 in IDLE -> HI=0x00001234 next edge, LO unchanged, one DONE pulse.
6. Assert RST during RUN cycle 10 of a MULT -> BUSY=0, HI=LO=0 immediately, no DONE pulse. A new MULTU after release completes normally. A START held during the FINISH cycle starts RUN on the next edge with no idle gap.
